// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice path: the default sample
// width (shared with the wavetable instrument) and the sample FSM states.
package synth_pkg;

    localparam int unsigned RESOLUCAO_PADRAO = 8;

    typedef enum logic [2:0] {
        OCIOSO,
        PEDE,
        AGUARDA,
        CAPTURA,
        SEGURA
    } estado_e;

endpackage

// File: rtl/pwm_core.sv
// PWM core: free-running frame counter, duty compare and frame-start load of
// the playing duty value.
//   clk, rst_n     : clock, async active-low reset
//   habilita       : counter runs while high, everything held at 0 while low
//   buffer         : captured sample, loaded into ativo at each frame start
//   pwm            : registered (cont_pwm < ativo)
//   ativo          : duty value currently being played
//   inicio_quadro  : high on the last clock of a frame (next clock is cont_pwm=0)
module pwm_core
    import synth_pkg::*;
#(
    parameter int unsigned RESOLUCAO = RESOLUCAO_PADRAO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 habilita,
    input  logic [RESOLUCAO-1:0] buffer,
    output logic                 pwm,
    output logic [RESOLUCAO-1:0] ativo,
    output logic                 inicio_quadro
);

    localparam logic [RESOLUCAO-1:0] CONT_MAX = {RESOLUCAO{1'b1}};

    logic [RESOLUCAO-1:0] cont_q;
    logic [RESOLUCAO-1:0] cont_d;
    logic [RESOLUCAO-1:0] ativo_q;
    logic [RESOLUCAO-1:0] ativo_d;
    logic                 pwm_q;
    logic                 inicio_q;

    // Next counter/duty; duty only changes as the counter wraps to 0
    always_comb begin
        cont_d  = '0;
        ativo_d = '0;
        if (habilita) begin
            cont_d  = cont_q + RESOLUCAO'(1);
            ativo_d = (cont_q == CONT_MAX) ? buffer : ativo_q;
        end
    end

    // Compare on next-state values so pwm lines up with cont_q/ativo_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q   <= '0;
            ativo_q  <= '0;
            pwm_q    <= 1'b0;
            inicio_q <= 1'b0;
        end else begin
            cont_q   <= cont_d;
            ativo_q  <= ativo_d;
            pwm_q    <= (cont_d < ativo_d);
            inicio_q <= (cont_d == CONT_MAX);
        end
    end

    assign pwm           = pwm_q;
    assign ativo         = ativo_q;
    assign inicio_quadro = inicio_q;

endmodule

// File: rtl/dac_pwm.sv
// Audio output stage: requests one sample per period from the instrument
// (prox), captures it ATRASO clocks later and plays it as PWM for the
// following QUADROS frames.
//   clk, rst_n : clock, async active-low reset
//   habilita   : play enable; low mutes and parks the FSM in OCIOSO
//   amostra    : unsigned sample from the instrument
//   prox       : one-clock next-sample request strobe
//   pwm        : 1-bit PWM audio output
//   ativo      : duty value currently being played
module dac_pwm
    import synth_pkg::*;
#(
    parameter int unsigned RESOLUCAO = RESOLUCAO_PADRAO,
    parameter int unsigned QUADROS   = 4,
    parameter int unsigned ATRASO    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 habilita,
    input  logic [RESOLUCAO-1:0] amostra,
    output logic                 prox,
    output logic                 pwm,
    output logic [RESOLUCAO-1:0] ativo
);

    localparam int unsigned          QW          = (QUADROS > 1) ? $clog2(QUADROS) : 1;
    localparam logic [QW-1:0]        QUADRO_ULT  = QW'(QUADROS - 1);
    localparam logic [RESOLUCAO-1:0] ESPERA_ALVO = RESOLUCAO'(ATRASO);

    estado_e              estado_q;
    logic                 prox_q;
    logic [RESOLUCAO-1:0] buffer_q;
    logic [RESOLUCAO-1:0] espera_q;
    logic [QW-1:0]        quadro_q;
    logic                 roda;
    logic                 inicio_quadro;
    logic                 fim_periodo;

    // Counters start one clock after enable so PEDE lands on cont_pwm=0
    assign roda        = habilita && (estado_q != OCIOSO);
    assign fim_periodo = inicio_quadro && (quadro_q == QUADRO_ULT);

    pwm_core #(
        .RESOLUCAO(RESOLUCAO)
    ) u_pwm_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .habilita      (roda),
        .buffer        (buffer_q),
        .pwm           (pwm),
        .ativo         (ativo),
        .inicio_quadro (inicio_quadro)
    );

    // Sample FSM; espera_q mirrors cont_pwm while in AGUARDA, and the sample
    // is latched on the edge that enters CAPTURA (end of cycle t+ATRASO)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            prox_q   <= 1'b0;
            buffer_q <= '0;
            espera_q <= '0;
            quadro_q <= '0;
        end else if (!habilita) begin
            estado_q <= OCIOSO;
            prox_q   <= 1'b0;
            quadro_q <= '0;
        end else begin
            prox_q <= 1'b0;
            if (inicio_quadro) begin
                quadro_q <= (quadro_q == QUADRO_ULT) ? '0 : quadro_q + QW'(1);
            end
            case (estado_q)
                OCIOSO: begin
                    estado_q <= PEDE;
                    prox_q   <= 1'b1;
                end
                PEDE: begin
                    estado_q <= AGUARDA;
                    espera_q <= RESOLUCAO'(1);
                end
                AGUARDA: begin
                    if (espera_q == ESPERA_ALVO) begin
                        estado_q <= CAPTURA;
                        buffer_q <= amostra;
                    end else begin
                        espera_q <= espera_q + RESOLUCAO'(1);
                    end
                end
                // CAPTURA may already sit on the period end when ATRASO is maximal
                CAPTURA, SEGURA: begin
                    if (fim_periodo) begin
                        estado_q <= PEDE;
                        prox_q   <= 1'b1;
                    end else begin
                        estado_q <= SEGURA;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign prox = prox_q;

endmodule

// File: tb/tb_dac_pwm.sv
// Bench for dac_pwm: a default instance (QUADROS=4, ATRASO=2) and a
// QUADROS=1, ATRASO=1 instance share clock, reset and enable; each is fed by
// its own wavetable instrument model.
module tb_dac_pwm;

    localparam int unsigned NP   = 256;
    localparam int unsigned PER0 = 1024;
    localparam int unsigned PER1 = 256;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  val;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic       habilita;
    logic [7:0] amostra0, amostra1;
    logic       prox0, prox1;
    logic       pwm0, pwm1;
    logic [7:0] ativo0, ativo1;

    logic [7:0]  tbl [8];
    int unsigned cyc;
    int unsigned n_chk;
    int unsigned n_err;
    bit          run [2];
    bit          upd [2];
    int unsigned t0 [2];
    int unsigned per [2];
    int unsigned ptr [2];
    int unsigned hi [2];
    logic [7:0]  exp_ativo [2];
    logic [7:0]  frame_a [2];
    sb_t         q0 [$];
    sb_t         q1 [$];

    dac_pwm u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .habilita (habilita),
        .amostra  (amostra0),
        .prox     (prox0),
        .pwm      (pwm0),
        .ativo    (ativo0)
    );

    dac_pwm #(
        .RESOLUCAO (8),
        .QUADROS   (1),
        .ATRASO    (1)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .habilita (habilita),
        .amostra  (amostra1),
        .prox     (prox1),
        .pwm      (pwm1),
        .ativo    (ativo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: advance instrument models, then check both DUTs
    task automatic step(output bit saw0);
        logic        p;
        logic        w;
        logic [7:0]  a;
        bit          vivo;
        int unsigned rel;
        int unsigned ph;
        sb_t         e;
        @(posedge clk);
        #1;
        cyc++;
        saw0 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (upd[d]) begin
                upd[d] = 1'b0;
                ptr[d] = (ptr[d] + 1) % 8;
                if (d == 0) amostra0 = tbl[ptr[d]];
                else        amostra1 = tbl[ptr[d]];
                if (run[d]) begin
                    e.due = cyc - 1 + NP;
                    e.val = tbl[ptr[d]];
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            p = (d == 0) ? prox0 : prox1;
            w = (d == 0) ? pwm0 : pwm1;
            a = (d == 0) ? ativo0 : ativo1;
            vivo = run[d] && (cyc >= t0[d]);
            rel  = vivo ? (cyc - t0[d]) : 0;
            ph   = rel % NP;
            check_eq($sformatf("prox%0d", d), 32'(p), (vivo && (rel % per[d] == 0)) ? 1 : 0);
            if (d == 0) begin
                if (q0.size() > 0 && q0[0].due == cyc) begin
                    exp_ativo[0] = q0[0].val;
                    void'(q0.pop_front());
                end
            end else begin
                if (q1.size() > 0 && q1[0].due == cyc) begin
                    exp_ativo[1] = q1[0].val;
                    void'(q1.pop_front());
                end
            end
            check_eq($sformatf("ativo%0d", d), 32'(a), 32'(exp_ativo[d]));
            if (vivo) begin
                if (ph == 0) begin
                    frame_a[d] = exp_ativo[d];
                    hi[d]      = 0;
                end
                hi[d] += 32'(w);
                if (ph == NP - 1) check_eq($sformatf("duty%0d", d), hi[d], 32'(frame_a[d]));
            end else begin
                check_eq($sformatf("pwm_mute%0d", d), 32'(w), 0);
            end
            if (p) upd[d] = 1'b1;
            if (d == 0) saw0 = p;
        end
    endtask

    task automatic liga();
        habilita = 1'b1;
        for (int d = 0; d < 2; d++) begin
            run[d] = 1'b1;
            t0[d]  = cyc + 1;
        end
    endtask

    task automatic desliga();
        habilita = 1'b0;
        for (int d = 0; d < 2; d++) begin
            run[d]       = 1'b0;
            exp_ativo[d] = 8'd0;
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        bit saw;
        bit found;
        tbl = '{8'd127, 8'd219, 8'd255, 8'd215, 8'd121, 8'd31, 8'd0, 8'd45};
        cyc   = 0;
        n_chk = 0;
        n_err = 0;
        per[0] = PER0;
        per[1] = PER1;
        for (int d = 0; d < 2; d++) begin
            run[d]       = 1'b0;
            upd[d]       = 1'b0;
            t0[d]        = 0;
            ptr[d]       = 0;
            hi[d]        = 0;
            exp_ativo[d] = 8'd0;
            frame_a[d]   = 8'd0;
        end
        rst_n    = 1'b0;
        habilita = 1'b0;
        amostra0 = tbl[0];
        amostra1 = tbl[0];

        // Reset state, then a short idle stretch
        repeat (5) step(saw);
        rst_n = 1'b1;
        repeat (20) step(saw);

        // Full instrument sequence over 8 default periods (32 for QUADROS=1)
        liga();
        repeat (8 * PER0 + 100) step(saw);

        // Drop enable while the default instance sits in AGUARDA
        found = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step(saw);
            if (saw) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("wait_prox0", 32'(found), 1);
        step(saw);
        desliga();
        repeat (300) step(saw);

        // Re-enable and let the cadence resume
        liga();
        repeat (4 * PER0 + 350) step(saw);

        // Reset mid-run, then hold disabled
        rst_n = 1'b0;
        desliga();
        upd[0] = 1'b0;
        upd[1] = 1'b0;
        repeat (10) step(saw);
        rst_n = 1'b1;
        repeat (2000) step(saw);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
